// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two requesters, the memory port and the arbiter.
// The arbiter takes the master view because it masters the memory port; the environment takes the slave view.
interface mem_port_arbiter_if;
    logic        r0_req, r0_we, r0_gnt, r0_done;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_gnt, r1_done;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    modport master (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_read_data,
        output r0_gnt, r0_done, r0_rdata,
        output r1_gnt, r1_done, r1_rdata,
        output mem_addr, mem_write_data, mem_read, mem_write
    );

    modport slave (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_read_data,
        input  r0_gnt, r0_done, r0_rdata,
        input  r1_gnt, r1_done, r1_rdata,
        input  mem_addr, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a fixed-latency memory port (IDLE -> ACCESS -> DONE).
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise r0 has fixed priority.
module mem_port_arbiter #(
    parameter int RD_LAT = 3,
    parameter int WR_LAT = 1
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.master bus
);
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             first_q, first_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [31:0]      rdata0_q, rdata0_d;
    logic [31:0]      rdata1_q, rdata1_d;

    logic any_req, win, win_we;

    assign any_req = bus.r0_req | bus.r1_req;
    assign win_we  = win ? bus.r1_we : bus.r0_we;

`ifdef ARB_ROUND_ROBIN_EN
    // prio_q names the requester that wins the next tie; it flips away from whoever was just granted.
    logic prio_q, prio_d;

    assign win = bus.r0_req ? (bus.r1_req & prio_q) : 1'b1;

    always_comb begin
        prio_d = prio_q;
        if (state_q == S_IDLE && any_req)
            prio_d = ~win;
    end

    always_ff @(posedge clk) begin
        if (reset) prio_q <= 1'b0;
        else       prio_q <= prio_d;
    end
`else
    assign win = ~bus.r0_req;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        first_d  = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_ACCESS;
                    owner_d = win;
                    first_d = 1'b1;
                    addr_d  = win ? bus.r1_addr  : bus.r0_addr;
                    wdata_d = win ? bus.r1_wdata : bus.r0_wdata;
                    cnt_d   = win_we ? WR_CNT : RD_CNT;
                    rd_d    = ~win_we;
                    wr_d    = win_we;
                end
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    // Last enable cycle: memory data is valid now, enables drop at this edge.
                    if (rd_q) begin
                        if (owner_q) rdata1_d = bus.mem_read_data;
                        else         rdata0_d = bus.mem_read_data;
                    end
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            first_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            first_q  <= first_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.r0_gnt         = (state_q == S_ACCESS) & first_q & ~owner_q;
    assign bus.r1_gnt         = (state_q == S_ACCESS) & first_q &  owner_q;
    assign bus.r0_done        = (state_q == S_DONE) & ~owner_q;
    assign bus.r1_done        = (state_q == S_DONE) &  owner_q;
    assign bus.r0_rdata       = rdata0_q;
    assign bus.r1_rdata       = rdata1_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.mem_read       = rd_q;
    assign bus.mem_write      = wr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut_a uses RD_LAT=3/WR_LAT=1, dut_b uses RD_LAT=1/WR_LAT=4.
// The memory model returns addr ^ 0xDEADBFEF only on the final mem_read cycle, and 0xBAD0BAD0 otherwise.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if ba();
    mem_port_arbiter_if bb();

    mem_port_arbiter #(.RD_LAT(3), .WR_LAT(1)) dut_a (.clk(clk), .reset(reset), .bus(ba));
    mem_port_arbiter #(.RD_LAT(1), .WR_LAT(4)) dut_b (.clk(clk), .reset(reset), .bus(bb));

    int unsigned rda_n = 0;
    int unsigned rdb_n = 0;
    always @(posedge clk) rda_n <= ba.mem_read ? rda_n + 1 : 0;
    always @(posedge clk) rdb_n <= bb.mem_read ? rdb_n + 1 : 0;
    assign ba.mem_read_data = (ba.mem_read && rda_n == 2) ? (ba.mem_addr ^ 32'hDEADBFEF) : 32'hBAD0BAD0;
    assign bb.mem_read_data = (bb.mem_read && rdb_n == 0) ? (bb.mem_addr ^ 32'hDEADBFEF) : 32'hBAD0BAD0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ba.r0_req = 1'b1; ba.r0_we = 1'b0; ba.r0_addr = 32'h0000_0ABC;
        repeat (2) tick();
        n_chk++; if (ba.mem_read !== 1'b0 || ba.mem_write !== 1'b0) $display("FAIL reset_en: rd=%b wr=%b exp 0 0", ba.mem_read, ba.mem_write); else n_pass++;
        n_chk++; if (ba.mem_addr !== 32'h0 || ba.mem_write_data !== 32'h0) $display("FAIL reset_bus: addr=%h wd=%h exp 0 0", ba.mem_addr, ba.mem_write_data); else n_pass++;
        n_chk++; if ({ba.r0_gnt, ba.r1_gnt, ba.r0_done, ba.r1_done} !== 4'b0) $display("FAIL reset_hs: got %b exp 0000", {ba.r0_gnt, ba.r1_gnt, ba.r0_done, ba.r1_done}); else n_pass++;
        n_chk++; if (ba.r0_rdata !== 32'h0 || ba.r1_rdata !== 32'h0) $display("FAIL reset_rdata: %h %h exp 0 0", ba.r0_rdata, ba.r1_rdata); else n_pass++;
        n_chk++; if (bb.mem_read !== 1'b0 || bb.mem_write !== 1'b0) $display("FAIL reset_b_en: rd=%b wr=%b exp 0 0", bb.mem_read, bb.mem_write); else n_pass++;
        ba.r0_req = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_read();
        ba.r0_req = 1'b1; ba.r0_we = 1'b0; ba.r0_addr = 32'h100; ba.r0_wdata = 32'h0;
        tick(); // T1
        n_chk++; if (ba.r0_gnt !== 1'b1 || ba.r1_gnt !== 1'b0) $display("FAIL read_gnt: r0=%b r1=%b exp 1 0", ba.r0_gnt, ba.r1_gnt); else n_pass++;
        n_chk++; if (ba.mem_read !== 1'b1 || ba.mem_addr !== 32'h100) $display("FAIL read_t1: rd=%b addr=%h exp 1 100", ba.mem_read, ba.mem_addr); else n_pass++;
        ba.r0_req = 1'b0; ba.r0_addr = 32'hFFFF_FFFF;
        tick(); // T2
        n_chk++; if (ba.r0_gnt !== 1'b0 || ba.mem_read !== 1'b1 || ba.mem_addr !== 32'h100) $display("FAIL read_t2: gnt=%b rd=%b addr=%h exp 0 1 100", ba.r0_gnt, ba.mem_read, ba.mem_addr); else n_pass++;
        tick(); // T3
        n_chk++; if (ba.mem_read !== 1'b1 || ba.r0_done !== 1'b0) $display("FAIL read_t3: rd=%b done=%b exp 1 0", ba.mem_read, ba.r0_done); else n_pass++;
        tick(); // T4
        n_chk++; if (ba.r0_done !== 1'b1 || ba.mem_read !== 1'b0) $display("FAIL read_t4: done=%b rd=%b exp 1 0", ba.r0_done, ba.mem_read); else n_pass++;
        n_chk++; if (ba.r0_rdata !== 32'hDEADBEEF) $display("FAIL read_data: got %h exp deadbeef", ba.r0_rdata); else n_pass++;
        tick(); // T5
        n_chk++; if (ba.r0_done !== 1'b0) $display("FAIL read_done_pulse: got %b exp 0", ba.r0_done); else n_pass++;
    endtask

    task automatic test_write();
        ba.r1_req = 1'b1; ba.r1_we = 1'b1; ba.r1_addr = 32'h200; ba.r1_wdata = 32'h12345678;
        tick(); // T1
        n_chk++; if (ba.r1_gnt !== 1'b1 || ba.mem_write !== 1'b1 || ba.mem_read !== 1'b0) $display("FAIL write_t1: gnt=%b wr=%b rd=%b exp 1 1 0", ba.r1_gnt, ba.mem_write, ba.mem_read); else n_pass++;
        n_chk++; if (ba.mem_addr !== 32'h200 || ba.mem_write_data !== 32'h12345678) $display("FAIL write_bus: addr=%h wd=%h exp 200 12345678", ba.mem_addr, ba.mem_write_data); else n_pass++;
        ba.r1_req = 1'b0; ba.r1_we = 1'b0;
        tick(); // T2
        n_chk++; if (ba.r1_done !== 1'b1 || ba.mem_write !== 1'b0) $display("FAIL write_t2: done=%b wr=%b exp 1 0", ba.r1_done, ba.mem_write); else n_pass++;
        n_chk++; if (ba.r1_rdata !== 32'h0 || ba.r0_rdata !== 32'hDEADBEEF) $display("FAIL write_rdata: r1=%h r0=%h exp 0 deadbeef", ba.r1_rdata, ba.r0_rdata); else n_pass++;
        tick();
    endtask

    task automatic test_tie();
        int g[$];
        int gc[$];
        int cyc = 0;
        int exp_g[4];
        logic [31:0] exp_r1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
        exp_r1 = 32'hDEADBCEB;
`else
        exp_g = '{0, 0, 0, 0};
        exp_r1 = 32'h0;
`endif
        ba.r0_req = 1'b1; ba.r0_we = 1'b0; ba.r0_addr = 32'h300;
        ba.r1_req = 1'b1; ba.r1_we = 1'b0; ba.r1_addr = 32'h304;
        while (g.size() < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (ba.r0_gnt) begin g.push_back(0); gc.push_back(cyc); end
            if (ba.r1_gnt) begin g.push_back(1); gc.push_back(cyc); end
        end
        ba.r0_req = 1'b0; ba.r1_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int got;
            got = (i < g.size()) ? g[i] : -1;
            n_chk++; if (got !== exp_g[i]) $display("FAIL tie_grant%0d: got r%0d exp r%0d", i, got, exp_g[i]); else n_pass++;
        end
        n_chk++; if (gc.size() < 2 || gc[1] - gc[0] != 5) $display("FAIL tie_spacing: got %0d grants, gap %0d exp gap 5", gc.size(), (gc.size() < 2) ? -1 : gc[1] - gc[0]); else n_pass++;
        repeat (5) tick();
        n_chk++; if (ba.r0_rdata !== 32'hDEADBCEF || ba.r1_rdata !== exp_r1) $display("FAIL tie_rdata: r0=%h r1=%h exp deadbcef %h", ba.r0_rdata, ba.r1_rdata, exp_r1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int gc[$];
        logic ovl = 1'b0;
        ba.r0_req = 1'b1; ba.r0_we = 1'b0; ba.r0_addr = 32'h400;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ba.mem_read && ba.mem_write) ovl = 1'b1;
            if (ba.r0_gnt) gc.push_back(c);
            if (gc.size() == 2) ba.r0_req = 1'b0;
        end
        n_chk++; if (gc.size() != 2 || gc[0] != 1 || gc[1] != 6) $display("FAIL b2b_gnt: got %0d grants first %0d second %0d exp 2 1 6", gc.size(), (gc.size() > 0) ? gc[0] : -1, (gc.size() > 1) ? gc[1] : -1); else n_pass++;
        n_chk++; if (ovl !== 1'b0) $display("FAIL b2b_overlap: got %b exp 0", ovl); else n_pass++;
        n_chk++; if (ba.r0_rdata !== 32'hDEADBBEF) $display("FAIL b2b_rdata: got %h exp deadbbef", ba.r0_rdata); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic spur = 1'b0;
        ba.r0_req = 1'b1; ba.r0_we = 1'b0; ba.r0_addr = 32'h500;
        tick(); // T1
        n_chk++; if (ba.r0_gnt !== 1'b1) $display("FAIL rstmid_gnt: got %b exp 1", ba.r0_gnt); else n_pass++;
        ba.r0_req = 1'b0;
        tick(); // T2
        reset = 1'b1;
        tick(); // T3
        n_chk++; if (ba.mem_read !== 1'b0 || ba.r0_done !== 1'b0 || ba.r0_rdata !== 32'h0) $display("FAIL rstmid_t3: rd=%b done=%b rdata=%h exp 0 0 0", ba.mem_read, ba.r0_done, ba.r0_rdata); else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ba.r0_done || ba.r0_gnt || ba.mem_read) spur = 1'b1;
        end
        n_chk++; if (spur !== 1'b0) $display("FAIL rstmid_aborted: got activity %b exp 0", spur); else n_pass++;
        ba.r1_req = 1'b1; ba.r1_we = 1'b0; ba.r1_addr = 32'h600;
        tick(); // T1
        n_chk++; if (ba.r1_gnt !== 1'b1 || ba.mem_read !== 1'b1) $display("FAIL rstmid_new_gnt: gnt=%b rd=%b exp 1 1", ba.r1_gnt, ba.mem_read); else n_pass++;
        ba.r1_req = 1'b0;
        repeat (3) tick(); // T4
        n_chk++; if (ba.r1_done !== 1'b1 || ba.r1_rdata !== 32'hDEADB9EF || ba.r0_rdata !== 32'h0) $display("FAIL rstmid_new_done: done=%b r1=%h r0=%h exp 1 deadb9ef 0", ba.r1_done, ba.r1_rdata, ba.r0_rdata); else n_pass++;
        tick();
    endtask

    task automatic test_params();
        bb.r0_req = 1'b1; bb.r0_we = 1'b0; bb.r0_addr = 32'h700;
        tick(); // T1
        n_chk++; if (bb.r0_gnt !== 1'b1 || bb.mem_read !== 1'b1) $display("FAIL p_read_t1: gnt=%b rd=%b exp 1 1", bb.r0_gnt, bb.mem_read); else n_pass++;
        bb.r0_req = 1'b0;
        tick(); // T2
        n_chk++; if (bb.r0_done !== 1'b1 || bb.mem_read !== 1'b0 || bb.r0_rdata !== 32'hDEADB8EF) $display("FAIL p_read_t2: done=%b rd=%b rdata=%h exp 1 0 deadb8ef", bb.r0_done, bb.mem_read, bb.r0_rdata); else n_pass++;
        tick();
        bb.r1_req = 1'b1; bb.r1_we = 1'b1; bb.r1_addr = 32'h710; bb.r1_wdata = 32'hA5A5A5A5;
        tick(); // T1
        n_chk++; if (bb.r1_gnt !== 1'b1) $display("FAIL p_write_gnt: got %b exp 1", bb.r1_gnt); else n_pass++;
        bb.r1_req = 1'b0; bb.r1_addr = 32'h0; bb.r1_wdata = 32'h0;
        for (int i = 1; i <= 4; i++) begin
            n_chk++; if (bb.mem_write !== 1'b1 || bb.mem_addr !== 32'h710 || bb.mem_write_data !== 32'hA5A5A5A5 || bb.r1_done !== 1'b0) $display("FAIL p_write_T%0d: wr=%b addr=%h wd=%h done=%b exp 1 710 a5a5a5a5 0", i, bb.mem_write, bb.mem_addr, bb.mem_write_data, bb.r1_done); else n_pass++;
            tick();
        end
        n_chk++; if (bb.r1_done !== 1'b1 || bb.mem_write !== 1'b0 || bb.r1_rdata !== 32'h0) $display("FAIL p_write_t5: done=%b wr=%b rdata=%h exp 1 0 0", bb.r1_done, bb.mem_write, bb.r1_rdata); else n_pass++;
        tick();
    endtask

    initial begin
        ba.r0_req = 1'b0; ba.r0_we = 1'b0; ba.r0_addr = '0; ba.r0_wdata = '0;
        ba.r1_req = 1'b0; ba.r1_we = 1'b0; ba.r1_addr = '0; ba.r1_wdata = '0;
        bb.r0_req = 1'b0; bb.r0_we = 1'b0; bb.r0_addr = '0; bb.r0_wdata = '0;
        bb.r1_req = 1'b0; bb.r1_we = 1'b0; bb.r1_addr = '0; bb.r1_wdata = '0;
        test_reset();
        test_read();
        test_write();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_params();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
